entry_sequencer: RTL
====================

Name: entry_sequencer

Overview:
- Top-level input controller for the A5/1 encrypt/decrypt path.
- Consumes decoded keystrokes and steps through four phases: key entry, data entry, cipher run, result hold.
- Owns the key and data write indices, including backspace handling and bounds checks.
- Issues buffer writes and a single-cycle cipher start.

Parameters:
- KEY_CHARS, 8: number of ASCII characters forming the 64-bit session key.
- DATA_MAX, 32: maximum number of message characters.
- IDX_W, 6: index width. Must satisfy 2^IDX_W > DATA_MAX and 2^IDX_W > KEY_CHARS.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- key_valid  in  1  one-cycle strobe; a decoded keystroke is present.
- key_ascii  in  8  ASCII code, valid with key_valid.
- key_enter  in  1  keystroke is Enter, valid with key_valid.
- key_bksp  in  1  keystroke is Backspace, valid with key_valid.
- cipher_done  in  1  one-cycle pulse from the cipher core; run complete.
- mode  out  2  current state: 0 KEY, 1 DATA, 2 RUN, 3 DONE.
- wr_en  out  1  buffer write strobe.
- wr_sel  out  1  write target: 0 key buffer, 1 data buffer.
- wr_addr  out  IDX_W  buffer write address.
- wr_data  out  8  byte to write.
- key_len  out  IDX_W  characters currently in the key.
- data_len  out  IDX_W  characters currently in the message.
- cipher_start  out  1  one-cycle start pulse to the cipher core.
- err  out  1  one-cycle pulse when a keystroke is rejected.

Behaviour:
- Reset values: all outputs 0, mode=KEY, key_len=0, data_len=0. Reset wins over every other event in the same cycle, including mid-RUN; a later cipher_done is then ignored.
- Keystroke classes, evaluated only when key_valid=1:
  - Enter: key_enter=1. Takes priority over backspace.
  - Backspace: key_bksp=1.
  - Printable: 0x20..0x7E.
  - Anything else is ignored silently: no err, no write.
- All outputs are registered, so a keystroke's effect appears exactly 1 cycle after key_valid.
- wr_en, cipher_start and err are single-cycle pulses. wr_addr, wr_sel and wr_data hold their values when wr_en=0.
- KEY state:
  - Printable with key_len<KEY_CHARS: write (sel=0, addr=key_len, data=ascii), then key_len+1.
  - Printable with key_len==KEY_CHARS: err, no write.
  - Backspace with key_len>0: write (sel=0, addr=key_len-1, data=0x00), then key_len-1.
  - Backspace with key_len==0: err, no change.
  - Enter with key_len==KEY_CHARS: go to DATA.
  - Enter with key_len<KEY_CHARS: err, stay in KEY.
- DATA state:
  - Same write and backspace rules as KEY, but against data_len, DATA_MAX and sel=1.
  - Backspace with data_len==0: return to KEY. key_len is unchanged; no err.
  - Enter with data_len>0: go to RUN, and cipher_start=1 in the same cycle mode becomes RUN.
  - Enter with data_len==0: err.
- RUN state:
  - Every keystroke produces err and nothing else.
  - cipher_done: go to DONE.
  - cipher_done coincident with key_valid: the transition occurs and the keystroke is dropped with err.
- DONE state:
  - Enter: go to DATA, data_len=0, key retained.
  - Backspace: go to KEY, key_len=0, data_len=0.
  - Printable: err.
- No counter ever wraps. Underflow and overflow are always rejected as above.
- cipher_done outside RUN is ignored.

Decomposition:
- Shared package holds the mode encodings (MODE_KEY=0, MODE_DATA=1, MODE_RUN=2, MODE_DONE=3), the ASCII constants (ASCII_NUL=0x00, PRINT_LO=0x20, PRINT_HI=0x7E) and the KEY_CHARS/DATA_MAX defaults.
- One sub-module, bounded_index. It is a synchronous up/down counter with:
  - inputs: inc, dec, clr and a limit;
  - outputs: value, at_zero, at_limit;
  - saturation at both ends.
- bounded_index is instantiated twice, once for key_len and once for data_len. The FSM and write-port registers stay in entry_sequencer.

Test Plan:
- Type 8 printable chars "ABCDEFGH" in KEY, then a 9th char → writes go to addr 0..7 with sel=0; key_len=8; the 9th char gives err=1 and no wr_en.
- From key_len=3, send Backspace ×4 → writes of 0x00 at addr 2,1,0; key_len reaches 0; the 4th Backspace gives err.
- Enter at key_len=5 → err, mode stays 0. Complete the key, Enter → mode=1.
- In DATA, type 32 chars, then a 33rd → data_len=32, the 33rd gives err. Enter → mode=2 with cipher_start high for exactly 1 cycle. Keys during RUN give err. cipher_done → mode=3.
- In DATA with data_len=0, Backspace → mode=0 and key_len=8 is kept. From DONE, Enter → mode=1 with data_len=0. From DONE, Backspace → mode=0 with key_len=0.
- Assert reset during RUN, then pulse cipher_done → all outputs 0, mode=0, no transition to DONE. Assert reset in the same cycle as key_valid → no write.

Source files
------------

// File: rtl/entry_sequencer_pkg.sv
// Shared definitions for the A5/1 entry sequencer: mode encodings, the
// ASCII constants used to classify keystrokes, and the default buffer sizes.
package entry_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_KEY  = 2'd0,
    MODE_DATA = 2'd1,
    MODE_RUN  = 2'd2,
    MODE_DONE = 2'd3
  } mode_e;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h7E;

  localparam int KEY_CHARS_DEF = 8;
  localparam int DATA_MAX_DEF  = 32;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/entry_sequencer_index.sv
// bounded_index: synchronous up/down counter that saturates at 0 and at
// `limit`. clr beats inc/dec; inc beats dec.
//   clock, reset : clock / synchronous active-high reset
//   inc, dec, clr: count controls
//   limit        : upper saturation bound
//   value        : current count
//   at_zero      : value == 0
//   at_limit     : value >= limit
module bounded_index #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] value,
  output logic         at_zero,
  output logic         at_limit
);

  assign at_zero  = (value == '0);
  assign at_limit = (value >= limit);

  always_ff @(posedge clock) begin
    if (reset || clr)             value <= '0;
    else if (inc && !at_limit)    value <= value + W'(1);
    else if (dec && !at_zero)     value <= value - W'(1);
  end

endmodule

// File: rtl/entry_sequencer.sv
// entry_sequencer: keystroke front end for the A5/1 encrypt/decrypt path.
// Walks KEY -> DATA -> RUN -> DONE, owns the key/data write indices and
// issues buffer writes plus a one-cycle cipher start. All outputs are
// registered, so a keystroke's effect shows one cycle after key_valid.
//   clock, reset           : clock / synchronous active-high reset
//   key_valid/ascii/enter/bksp : decoded keystroke strobe and attributes
//   cipher_done            : run-complete pulse from the cipher core
//   mode                   : 0 KEY, 1 DATA, 2 RUN, 3 DONE
//   wr_en/sel/addr/data    : buffer write port (sel 0 key, 1 data)
//   key_len, data_len      : characters currently held
//   cipher_start, err      : one-cycle pulses
module entry_sequencer
  import entry_sequencer_pkg::*;
#(
  parameter int KEY_CHARS = KEY_CHARS_DEF,
  parameter int DATA_MAX  = DATA_MAX_DEF,
  parameter int IDX_W     = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [7:0]       key_ascii,
  input  logic             key_enter,
  input  logic             key_bksp,
  input  logic             cipher_done,
  output logic [1:0]       mode,
  output logic             wr_en,
  output logic             wr_sel,
  output logic [IDX_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [IDX_W-1:0] key_len,
  output logic [IDX_W-1:0] data_len,
  output logic             cipher_start,
  output logic             err
);

  mode_e state;
  assign mode = state;

  // Keystroke classes; Enter outranks Backspace, anything non-printable
  // without either flag falls through and is ignored.
  logic kv_enter, kv_bksp, kv_print;
  assign kv_enter = key_valid & key_enter;
  assign kv_bksp  = key_valid & ~key_enter & key_bksp;
  assign kv_print = key_valid & ~key_enter & ~key_bksp & is_printable(key_ascii);

  logic in_key, in_data, in_done;
  assign in_key  = (state == MODE_KEY);
  assign in_data = (state == MODE_DATA);
  assign in_done = (state == MODE_DONE);

  logic key_empty, key_full, data_empty, data_full;

  // Counters saturate, so overflow/underflow keystrokes leave them unchanged
  // while the FSM below raises err instead of writing.
  bounded_index #(.W(IDX_W)) u_key_idx (
    .clock    (clock),
    .reset    (reset),
    .inc      (in_key & kv_print),
    .dec      (in_key & kv_bksp),
    .clr      (in_done & kv_bksp),
    .limit    (IDX_W'(KEY_CHARS)),
    .value    (key_len),
    .at_zero  (key_empty),
    .at_limit (key_full)
  );

  bounded_index #(.W(IDX_W)) u_data_idx (
    .clock    (clock),
    .reset    (reset),
    .inc      (in_data & kv_print),
    .dec      (in_data & kv_bksp),
    .clr      (in_done & (kv_enter | kv_bksp)),
    .limit    (IDX_W'(DATA_MAX)),
    .value    (data_len),
    .at_zero  (data_empty),
    .at_limit (data_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= MODE_KEY;
      wr_en        <= 1'b0;
      wr_sel       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cipher_start <= 1'b0;
      err          <= 1'b0;
    end else begin
      wr_en        <= 1'b0;
      cipher_start <= 1'b0;
      err          <= 1'b0;
      unique case (state)
        MODE_KEY: begin
          if (kv_enter) begin
            if (key_full) state <= MODE_DATA;
            else          err   <= 1'b1;
          end else if (kv_bksp) begin
            if (key_empty) err <= 1'b1;
            else begin
              wr_en   <= 1'b1;
              wr_sel  <= 1'b0;
              wr_addr <= key_len - IDX_W'(1);
              wr_data <= ASCII_NUL;
            end
          end else if (kv_print) begin
            if (key_full) err <= 1'b1;
            else begin
              wr_en   <= 1'b1;
              wr_sel  <= 1'b0;
              wr_addr <= key_len;
              wr_data <= key_ascii;
            end
          end
        end
        MODE_DATA: begin
          if (kv_enter) begin
            if (data_empty) err <= 1'b1;
            else begin
              state        <= MODE_RUN;
              cipher_start <= 1'b1;
            end
          end else if (kv_bksp) begin
            // Backspace on an empty message steps back to key editing.
            if (data_empty) state <= MODE_KEY;
            else begin
              wr_en   <= 1'b1;
              wr_sel  <= 1'b1;
              wr_addr <= data_len - IDX_W'(1);
              wr_data <= ASCII_NUL;
            end
          end else if (kv_print) begin
            if (data_full) err <= 1'b1;
            else begin
              wr_en   <= 1'b1;
              wr_sel  <= 1'b1;
              wr_addr <= data_len;
              wr_data <= key_ascii;
            end
          end
        end
        MODE_RUN: begin
          if (cipher_done) state <= MODE_DONE;
          if (kv_enter || kv_bksp || kv_print) err <= 1'b1;
        end
        MODE_DONE: begin
          if (kv_enter)      state <= MODE_DATA;
          else if (kv_bksp)  state <= MODE_KEY;
          else if (kv_print) err   <= 1'b1;
        end
      endcase
    end
  end

endmodule
